// File: rtl/mem_data_arbiter.sv
// Arbitrates the single data-memory port between the nRisc core and an external
// req/ack requester; the core has priority, bounded by a starvation limit.
module mem_data_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CoreMemRead,
  input  logic              CoreMemWrite,
  input  logic [ADDR_W-1:0] CoreEndereco,
  input  logic [DATA_W-1:0] CoreDadoEscrito,
  output logic [DATA_W-1:0] CoreDadoLido,
  output logic              CoreStall,
  input  logic              ExtReq,
  input  logic              ExtWe,
  input  logic [ADDR_W-1:0] ExtEndereco,
  input  logic [DATA_W-1:0] ExtDado,
  output logic              ExtAck,
  output logic [DATA_W-1:0] ExtDadoLido,
  output logic [ADDR_W-1:0] MemEndereco,
  output logic [DATA_W-1:0] MemDadoEscr,
  input  logic [DATA_W-1:0] MemDadoLido,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [7:0]        ContConflitos
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, EXT_ACK} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             core_req;
  logic             ext_grant;
  logic             core_grant;

  // Grant decision for the current cycle; reset blocks every grant.
  always_comb begin
    core_req   = CoreMemRead | CoreMemWrite;
    ext_grant  = 1'b0;
    core_grant = 1'b0;
    if (!Reset) begin
      if (state == IDLE && ExtReq && (!core_req || starve_cnt >= LIMIT))
        ext_grant = 1'b1;
      else if (core_req)
        core_grant = 1'b1;
    end
  end

  // Memory port mux; a simultaneous core read+write resolves to a write.
  always_comb begin
    MemEndereco = '0;
    MemDadoEscr = '0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    if (core_grant) begin
      MemEndereco = CoreEndereco;
      MemDadoEscr = CoreDadoEscrito;
      MemWrite    = CoreMemWrite;
      MemRead     = CoreMemRead & ~CoreMemWrite;
    end else if (ext_grant) begin
      MemEndereco = ExtEndereco;
      MemDadoEscr = ExtDado;
      MemWrite    = ExtWe;
      MemRead     = ~ExtWe;
    end
  end

  assign CoreStall    = core_req & ext_grant;
  assign CoreDadoLido = MemDadoLido;

  // Handshake state, starvation counter, read capture and conflict counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      ExtAck        <= 1'b0;
      ExtDadoLido   <= '0;
      ContConflitos <= '0;
    end else begin
      state  <= ext_grant ? EXT_ACK : IDLE;
      ExtAck <= ext_grant;
      if (ext_grant && !ExtWe)
        ExtDadoLido <= MemDadoLido;
      if (!ExtReq || ext_grant)
        starve_cnt <= '0;
      else if (state == IDLE && core_grant && starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + CNT_W'(1);
      if (state == IDLE && ExtReq && core_req && ContConflitos != 8'hFF)
        ContConflitos <= ContConflitos + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Self-checking bench for mem_data_arbiter: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_mem_data_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned LIM = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          CoreMemRead, CoreMemWrite;
  logic [AW-1:0] CoreEndereco;
  logic [DW-1:0] CoreDadoEscrito;
  logic [DW-1:0] CoreDadoLido;
  logic          CoreStall;
  logic          ExtReq, ExtWe;
  logic [AW-1:0] ExtEndereco;
  logic [DW-1:0] ExtDado;
  logic          ExtAck;
  logic [DW-1:0] ExtDadoLido;
  logic [AW-1:0] MemEndereco;
  logic [DW-1:0] MemDadoEscr;
  logic [DW-1:0] MemDadoLido;
  logic          MemWrite, MemRead;
  logic [7:0]    ContConflitos;

  always #5 Clock = ~Clock;

  mem_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .Clock(Clock), .Reset(Reset),
    .CoreMemRead(CoreMemRead), .CoreMemWrite(CoreMemWrite),
    .CoreEndereco(CoreEndereco), .CoreDadoEscrito(CoreDadoEscrito),
    .CoreDadoLido(CoreDadoLido), .CoreStall(CoreStall),
    .ExtReq(ExtReq), .ExtWe(ExtWe), .ExtEndereco(ExtEndereco), .ExtDado(ExtDado),
    .ExtAck(ExtAck), .ExtDadoLido(ExtDadoLido),
    .MemEndereco(MemEndereco), .MemDadoEscr(MemDadoEscr), .MemDadoLido(MemDadoLido),
    .MemWrite(MemWrite), .MemRead(MemRead), .ContConflitos(ContConflitos)
  );

  // Behavioural data memory with bench-side clear/preload.
  logic [7:0] mem [256];
  logic       mem_clr, pl_en;
  logic [7:0] pl_addr, pl_data;

  always @(posedge Clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (MemWrite) begin
      mem[MemEndereco] <= MemDadoEscr;
    end
  end
  assign MemDadoLido = mem[MemEndereco];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: "in ack phase" flag, counters and a shadow memory.
  logic [7:0] ref_mem [256];
  bit         m_ack;
  int         m_starve, m_conf;
  logic [7:0] m_rdata;

  // One cycle: inputs are already driven; check, clock, then advance the model.
  task automatic step();
    bit         creq, ext_win, core_win, e_we, e_re;
    logic [7:0] e_addr, e_data;
    #1;
    creq     = CoreMemRead || CoreMemWrite;
    ext_win  = 1'b0;
    core_win = 1'b0;
    if (!Reset) begin
      if (!m_ack && ExtReq && (!creq || m_starve >= int'(LIM))) ext_win = 1'b1;
      else if (creq) core_win = 1'b1;
    end
    e_we = 1'b0; e_re = 1'b0; e_addr = 8'h00; e_data = 8'h00;
    if (core_win) begin
      e_we = CoreMemWrite; e_re = CoreMemRead && !CoreMemWrite;
      e_addr = CoreEndereco; e_data = CoreDadoEscrito;
    end else if (ext_win) begin
      e_we = ExtWe; e_re = !ExtWe; e_addr = ExtEndereco; e_data = ExtDado;
    end
    check("mem_we",    MemWrite,      e_we);
    check("mem_re",    MemRead,       e_re);
    check("mem_addr",  MemEndereco,   e_addr);
    check("mem_wdata", MemDadoEscr,   e_data);
    check("stall",     CoreStall,     creq && ext_win);
    check("core_rd",   CoreDadoLido,  ref_mem[e_addr]);
    check("ext_ack",   ExtAck,        m_ack);
    check("ext_rdata", ExtDadoLido,   m_rdata);
    check("conflicts", ContConflitos, m_conf);
    @(posedge Clock);
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    end else if (pl_en) begin
      ref_mem[pl_addr] = pl_data;
    end else if (e_we) begin
      if (ext_win && !ExtWe) m_rdata = ref_mem[e_addr];
      ref_mem[e_addr] = e_data;
    end
    if (Reset) begin
      m_ack = 1'b0; m_starve = 0; m_conf = 0; m_rdata = 8'h00;
    end else begin
      if (ext_win && !ExtWe) m_rdata = ref_mem[ExtEndereco];
      if (!m_ack && ExtReq && creq && m_conf < 255) m_conf++;
      if (!ExtReq || ext_win) m_starve = 0;
      else if (!m_ack && core_win && m_starve < int'(LIM)) m_starve++;
      m_ack = ext_win;
    end
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    CoreMemRead = 0; CoreMemWrite = 0; CoreEndereco = 0; CoreDadoEscrito = 0;
    ExtReq = 0; ExtWe = 0; ExtEndereco = 0; ExtDado = 0;
    mem_clr = 0; pl_en = 0; pl_addr = 0; pl_data = 0;
  endtask

  task automatic do_reset(input int n);
    Reset = 1;
    for (int i = 0; i < n; i++) step();
    Reset = 0;
  endtask

  initial begin
    idle_inputs();
    Reset = 1; mem_clr = 1;
    m_ack = 0; m_starve = 0; m_conf = 0; m_rdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hxx;
    @(posedge Clock);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    @(negedge Clock);
    mem_clr = 0;
    pl_en = 1; pl_addr = 8'h20; pl_data = 8'h3C;
    step();
    pl_en = 0;
    do_reset(1);

    // External write, no contention.
    ExtReq = 1; ExtWe = 1; ExtEndereco = 8'h10; ExtDado = 8'hA5;
    #1; check("t1_we_c0", MemWrite, 1'b1); check("t1_addr_c0", MemEndereco, 8'h10);
    step();
    #1; check("t1_ack_c1", ExtAck, 1'b1);
    step();
    ExtReq = 0;
    #1; check("t1_ack_c2", ExtAck, 1'b0); check("t1_mem", mem[8'h10], 8'hA5);
    step();

    // External read, then a write that must not disturb the captured data.
    ExtReq = 1; ExtWe = 0; ExtEndereco = 8'h20;
    step();
    #1; check("t2_ack", ExtAck, 1'b1); check("t2_rdata", ExtDadoLido, 8'h3C);
    step();
    ExtWe = 1; ExtEndereco = 8'h21; ExtDado = 8'h99;
    step(); step();
    ExtReq = 0;
    #1; check("t2_hold", ExtDadoLido, 8'h3C);
    step();

    // Continuous core reads against a held external read.
    ExtReq = 1; ExtWe = 0; ExtEndereco = 8'h00;
    CoreMemRead = 1; CoreEndereco = 8'h01;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c <= 4) check("t3_nostall", CoreStall, 1'b0);
      if (c == 5) check("t3_stall", CoreStall, 1'b1);
      if (c == 6) begin
        check("t3_ack", ExtAck, 1'b1);
        check("t3_core_gnt", MemEndereco, 8'h01);
      end
      step();
    end
    ExtReq = 0;
    #1; check("t3_conf", ContConflitos, 8'd5);
    step();

    // Core read+write together resolves to a write.
    CoreMemRead = 1; CoreMemWrite = 1; CoreEndereco = 8'h05; CoreDadoEscrito = 8'h77;
    #1; check("t4_we", MemWrite, 1'b1); check("t4_re", MemRead, 1'b0);
    step();
    CoreMemRead = 0; CoreMemWrite = 0;
    #1; check("t4_mem", mem[8'h05], 8'h77);
    step();

    // Reset in the external grant cycle.
    ExtReq = 1; ExtWe = 1; ExtEndereco = 8'h30; ExtDado = 8'h5A; Reset = 1;
    #1; check("t5_we", MemWrite, 1'b0);
    step();
    Reset = 0; ExtReq = 0;
    #1;
    check("t5_ack", ExtAck, 1'b0);
    check("t5_conf", ContConflitos, 8'd0);
    check("t5_mem", mem[8'h30], 8'h00);
    step();

    // Conflict counter saturation.
    ExtReq = 1; ExtWe = 0; ExtEndereco = 8'h02; CoreMemRead = 1; CoreEndereco = 8'h03;
    for (int i = 0; i < 400; i++) step();
    #1; check("t6_sat", ContConflitos, 8'd255);
    step();
    ExtReq = 0; CoreMemRead = 0;
    do_reset(1);

    // Abort: external request drops while losing arbitration.
    CoreMemRead = 1; CoreEndereco = 8'h04;
    ExtReq = 1; ExtWe = 1; ExtEndereco = 8'h40; ExtDado = 8'hEE;
    step();
    ExtReq = 0;
    #1; check("ab_ack1", ExtAck, 1'b0);
    step();
    #1; check("ab_ack2", ExtAck, 1'b0); check("ab_mem", mem[8'h40], 8'h00);
    step();
    CoreMemRead = 0;

    // Randomized protocol-compliant traffic.
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 99) == 0);
      CoreMemRead  = ($urandom_range(0, 2) != 0);
      CoreMemWrite = ($urandom_range(0, 3) == 0);
      CoreEndereco = 8'($urandom_range(0, 15));
      CoreDadoEscrito = 8'($urandom);
      if (m_ack || !ExtReq) begin
        ExtReq = ($urandom_range(0, 1) == 1);
        ExtWe = ($urandom_range(0, 1) == 1);
        ExtEndereco = 8'($urandom_range(0, 15));
        ExtDado = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        ExtReq = 0;
      end
      step();
    end
    Reset = 0; idle_inputs();
    step();

    begin
      int bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
      check("mem_final", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
- Shares the single 8-bit data memory port between the nRisc core (requester 0) and an external requester (requester 1: loader/debug/DMA).
- Sits between nRisc and MemoriaDados. It drives MemWrite/MemRead/address/write data in place of the core.
- The core has priority, bounded by a starvation limit. The external side uses a req/ack handshake with registered read data and ack.
- A saturating conflict counter supports debug and performance inspection.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- STARVE_LIMIT, 4, maximum consecutive core grants while ExtReq is pending before the external requester is forced through (range 1..15).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- CoreMemRead  in  1  core read request.
- CoreMemWrite  in  1  core write request.
- CoreEndereco  in  ADDR_W  core address.
- CoreDadoEscrito  in  DATA_W  core write data.
- CoreDadoLido  out  DATA_W  core read data; combinational pass-through of MemDadoLido.
- CoreStall  out  1  core request not served this cycle; core holds its request.
- ExtReq  in  1  external request; held until ExtAck.
- ExtWe  in  1  1 = write, 0 = read; sampled with ExtReq.
- ExtEndereco  in  ADDR_W  external address.
- ExtDado  in  DATA_W  external write data.
- ExtAck  out  1  one-cycle completion pulse.
- ExtDadoLido  out  DATA_W  registered external read data.
- MemEndereco  out  ADDR_W  to memory address.
- MemDadoEscr  out  DATA_W  to memory write data.
- MemDadoLido  in  DATA_W  from memory read data.
- MemWrite  out  1  memory write enable; the memory writes on the rising edge.
- MemRead  out  1  memory read enable.
- ContConflitos  out  8  saturating count of cycles where both requesters competed.

Behaviour:
- **States:** IDLE and EXT_ACK, held in a registered state. starve_cnt is a 4-bit register.
- **Reset (Reset=1 at an edge):**
  - State becomes IDLE; starve_cnt=0; ExtAck=0; ExtDadoLido=0; ContConflitos=0.
  - While Reset=1, MemWrite=0, MemRead=0 and CoreStall=0, combinationally.
- **Core request:** core_req = CoreMemRead | CoreMemWrite. If both are high, the access is a write: MemWrite=1, MemRead=0.
- **Grant (combinational, current cycle):**
  - If state=EXT_ACK, the core is granted when core_req=1. The external requester is never granted in EXT_ACK, so there is no back-to-back issue.
  - If state=IDLE and ExtReq=0, the core is granted when core_req=1.
  - If state=IDLE, ExtReq=1 and core_req=0, the external requester is granted.
  - If state=IDLE, ExtReq=1, core_req=1 and starve_cnt<STARVE_LIMIT, the core is granted.
  - If state=IDLE, ExtReq=1, core_req=1 and starve_cnt=STARVE_LIMIT, the external requester is granted and CoreStall=1.
- **Memory mux:**
  - When the core is granted, Mem* is driven from the core signals.
  - When the external requester is granted, MemEndereco=ExtEndereco, MemDadoEscr=ExtDado, MemWrite=ExtWe, MemRead=~ExtWe.
  - With no grant, MemWrite=MemRead=0 and address/data are 0.
- **CoreStall:** 1 only when core_req=1 and the external requester is granted.
- **External grant edge:**
  - State goes to EXT_ACK.
  - If ExtWe=0, ExtDadoLido captures MemDadoLido; otherwise ExtDadoLido holds its value.
  - starve_cnt is cleared to 0.
- **EXT_ACK:** ExtAck=1 for exactly this one cycle, then the state returns to IDLE. If ExtReq is still high in IDLE, it is treated as a new transaction.
- **Transaction latency:** 2 cycles minimum (grant cycle plus ack cycle). Worst case is STARVE_LIMIT+2 cycles under continuous core traffic.
- **starve_cnt:**
  - Increments (saturating at STARVE_LIMIT) on each IDLE edge where ExtReq=1 and the core is granted.
  - Clears when ExtReq=0 or the external requester is granted.
- **ContConflitos:** increments on each edge where state=IDLE, ExtReq=1 and core_req=1. It saturates at 255 and never wraps.
- **Handshake protocol:**
  - The external requester keeps ExtReq, ExtWe, ExtEndereco and ExtDado stable until it sees ExtAck=1.
  - Dropping ExtReq before grant aborts cleanly with no access and no ack.
  - Changes to ExtReq during EXT_ACK are ignored.
- **Reset mid-transaction:** Reset during EXT_ACK forces ExtAck=0 from the next cycle. Reset in the grant cycle suppresses the memory write (MemWrite=0) and suppresses the ack.

Test Plan:
1. **External write, no contention:** Reset 2 cycles; ExtReq=1, ExtWe=1, ExtEndereco=0x10, ExtDado=0xA5.
   -> MemWrite=1 and MemEndereco=0x10 in cycle 0; ExtAck=1 in cycle 1 only; memory location 0x10 = 0xA5.
2. **External read:** memory 0x20 = 0x3C; ExtReq=1, ExtWe=0, ExtEndereco=0x20.
   -> ExtAck in cycle 1 with ExtDadoLido=0x3C; ExtDadoLido holds 0x3C after a subsequent ext write.
3. **Continuous core reads with ExtReq held (STARVE_LIMIT=4):**
   -> core granted 4 cycles with CoreStall=0; cycle 5 ext granted and CoreStall=1; cycle 6 ExtAck=1 and core granted; ContConflitos=5.
4. **Core read and write both asserted**, CoreEndereco=0x05, CoreDadoEscrito=0x77.
   -> MemWrite=1, MemRead=0; memory location 0x05 = 0x77.
5. **Reset mid-transaction:** assert Reset in the ext grant cycle of a write to 0x30 (memory 0x30 initially 0x00).
   -> MemWrite=0, no ExtAck, memory 0x30 stays 0x00; state IDLE and ContConflitos=0 after reset.
6. **Saturation:** 300 conflict cycles.
   -> ContConflitos stops at 255.
   
   **Abort:** ExtReq pulsed for 1 cycle while losing arbitration.
   -> no ext access and no ExtAck.
